// File: rtl/stq_pkg.sv
// Shared types for the merge output store queue: entry, packed line, FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 16
`endif
`ifndef DATA_PRECISION
`define DATA_PRECISION 32
`endif

package stq_pkg;

  localparam int STQ_BITS_ROW_IDX   = `BITS_ROW_IDX;
  localparam int STQ_DATA_PRECISION = `DATA_PRECISION;
  localparam int STQ_PACK_NUM       = 4;
  localparam int STQ_BITS_SLOT      = $clog2(STQ_PACK_NUM);

  // One merged (row, value) pair; row_idx sits in the upper bits of the slot.
  typedef struct packed {
    logic [STQ_BITS_ROW_IDX-1:0]   row_idx;
    logic [STQ_DATA_PRECISION-1:0] value;
  } stq_entry_t;

  // One memory line: slot 0 in the LSBs, plus a per-slot valid mask.
  typedef struct packed {
    stq_entry_t [STQ_PACK_NUM-1:0] slots;
    logic [STQ_PACK_NUM-1:0]       mask;
  } stq_line_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FLUSH_PACK = 2'd1,
    DRAIN      = 2'd2,
    DONE       = 2'd3
  } stq_state_t;

  // Thermometer mask with the lowest n bits set (n may equal STQ_PACK_NUM).
  function automatic logic [STQ_PACK_NUM-1:0] slot_mask(input logic [STQ_BITS_SLOT:0] n);
    logic [STQ_PACK_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < STQ_PACK_NUM; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

endpackage

// File: rtl/stq_line_fifo.sv
// Show-ahead line FIFO: head_line is the oldest entry whenever empty is low.
// Latency: a pushed line is visible at the head on the cycle after the push edge.
// Backpressure: caller must only push when !full or when popping on the same edge.
module stq_line_fifo
  import stq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int BITS_ADDR = 3
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               push,
  input  stq_line_t          push_line,
  input  logic               pop,
  output stq_line_t          head_line,
  output logic               empty,
  output logic               full,
  output logic [BITS_ADDR:0] count
);

  stq_line_t              mem [DEPTH];
  logic [BITS_ADDR-1:0]   wr_ptr;
  logic [BITS_ADDR-1:0]   rd_ptr;
  logic [BITS_ADDR:0]     cnt;

  // Line storage; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_line;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + BITS_ADDR'(1);
      if (pop)  rd_ptr <= rd_ptr + BITS_ADDR'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (BITS_ADDR+1)'(1);
        2'b01:   cnt <= cnt - (BITS_ADDR+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_line = mem[rd_ptr];
  assign empty     = (cnt == '0);
  assign full      = (cnt == (BITS_ADDR+1)'(DEPTH));
  assign count     = cnt;

endmodule

// File: rtl/merge_out_stq.sv
// Packs merged (row, value) pairs into memory lines, queues them and drains to the write port.
// Latency: last entry of a line -> mem_wr_valid in 1 cycle; partial line pushed the cycle after flush.
// Backpressure: registered buff_stq_full at FIFO margin; mem_wr valid/ready drain; overflow drops are sticky.
module merge_out_stq
  import stq_pkg::*;
#(
  parameter int BITS_ROW_IDX   = STQ_BITS_ROW_IDX,
  parameter int DATA_PRECISION = STQ_DATA_PRECISION,
  parameter int PACK_NUM       = STQ_PACK_NUM,
  parameter int STQ_DEPTH      = 8,
  parameter int BITS_STQ_ADDR  = 3,
  parameter int FULL_MARGIN    = 2,
  parameter int BITS_MEM_ADDR  = 32
) (
  input  logic                                        clk,
  input  logic                                        rst_b,
  input  logic                                        unit_en,
  input  logic                                        flush,
  input  logic [BITS_MEM_ADDR-1:0]                    base_addr,
  input  logic                                        in_valid,
  input  logic [BITS_ROW_IDX-1:0]                     in_row_idx,
  input  logic [DATA_PRECISION-1:0]                   in_value,
  output logic                                        buff_stq_full,
  output logic                                        mem_wr_valid,
  input  logic                                        mem_wr_ready,
  output logic [BITS_MEM_ADDR-1:0]                    mem_wr_addr,
  output logic [PACK_NUM*(BITS_ROW_IDX+DATA_PRECISION)-1:0] mem_wr_data,
  output logic [PACK_NUM-1:0]                         mem_wr_mask,
  output logic                                        flush_done,
  output logic                                        overflow_err
);

  localparam int BITS_SLOT = $clog2(PACK_NUM);
  localparam logic [BITS_SLOT-1:0]   LAST_SLOT = BITS_SLOT'(PACK_NUM - 1);
  localparam logic [BITS_STQ_ADDR:0] FULL_THR  = (BITS_STQ_ADDR+1)'(STQ_DEPTH - FULL_MARGIN);

  stq_state_t                 state_q;
  logic [BITS_SLOT-1:0]       slot_ctr;
  stq_entry_t [PACK_NUM-1:0]  pack_q;
  stq_entry_t [PACK_NUM-1:0]  pack_nxt;
  logic [BITS_SLOT:0]         cnt_nxt;
  logic [BITS_MEM_ADDR-1:0]   line_ctr;
  logic                       full_q;
  logic                       flush_done_q;
  logic                       overflow_q;

  logic                       accept;
  logic                       line_full;
  logic                       flush_pack;
  logic                       push_req;
  logic                       can_push;
  logic                       push;
  logic                       pop;
  logic                       drop;
  stq_line_t                  push_line;
  stq_line_t                  head_line;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic [BITS_STQ_ADDR:0]     fifo_count;
  logic [BITS_STQ_ADDR:0]     count_nxt;

  stq_line_fifo #(
    .DEPTH     (STQ_DEPTH),
    .BITS_ADDR (BITS_STQ_ADDR)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push),
    .push_line (push_line),
    .pop       (pop),
    .head_line (head_line),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Packer view of this cycle: the accepted entry is merged first, so a same-cycle
  // flush or a completing entry both see the updated slot count.
  always_comb begin
    accept     = unit_en && in_valid && (state_q != DONE);
    pack_nxt   = pack_q;
    if (accept) begin
      pack_nxt[slot_ctr] = '{row_idx: in_row_idx, value: in_value};
    end
    cnt_nxt    = {1'b0, slot_ctr} + {{BITS_SLOT{1'b0}}, accept};
    line_full  = accept && (slot_ctr == LAST_SLOT);
    flush_pack = unit_en && (state_q == FLUSH_PACK);
    push_req   = line_full || (flush_pack && (cnt_nxt != '0));
    pop        = mem_wr_valid && mem_wr_ready;
    can_push   = !fifo_full || pop;
    push       = push_req && can_push;
    drop       = line_full && !can_push;
    push_line.slots = pack_nxt;
    push_line.mask  = slot_mask(cnt_nxt);
    count_nxt  = fifo_count + {{BITS_STQ_ADDR{1'b0}}, push} - {{BITS_STQ_ADDR{1'b0}}, pop};
  end

  // Pack register is cleared on every push so unused slots of a partial line read as zero;
  // a dropped completing entry leaves the pack untouched.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      pack_q   <= '0;
      slot_ctr <= '0;
    end else if (push) begin
      pack_q   <= '0;
      slot_ctr <= '0;
    end else if (accept && !drop) begin
      pack_q   <= pack_nxt;
      slot_ctr <= cnt_nxt[BITS_SLOT-1:0];
    end
  end

  // Back-pressure looks at next-cycle occupancy; overflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      full_q <= (count_nxt >= FULL_THR);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Flush FSM plus line address counter; the counter restarts when a flush completes.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q      <= IDLE;
      flush_done_q <= 1'b0;
      line_ctr     <= '0;
    end else begin
      flush_done_q <= 1'b0;
      if (pop) line_ctr <= line_ctr + BITS_MEM_ADDR'(1);
      if (unit_en) begin
        case (state_q)
          IDLE: begin
            if (flush) state_q <= FLUSH_PACK;
          end
          FLUSH_PACK: begin
            if (!(push_req && !can_push)) state_q <= DRAIN;
          end
          DRAIN: begin
            if (fifo_empty) begin
              state_q      <= DONE;
              flush_done_q <= 1'b1;
            end
          end
          DONE: begin
            state_q  <= IDLE;
            line_ctr <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mem_wr_valid  = !fifo_empty;
  assign mem_wr_addr   = mem_wr_valid ? (base_addr + line_ctr) : '0;
  assign mem_wr_data   = mem_wr_valid ? head_line.slots : '0;
  assign mem_wr_mask   = mem_wr_valid ? head_line.mask : '0;
  assign buff_stq_full = full_q;
  assign flush_done    = flush_done_q;
  assign overflow_err  = overflow_q;

endmodule

// File: doc/merge_out_stq.md
Name: merge_out_stq

Overview:
- Output store queue directly downstream of the merge unit.
- Accepts merged (row_idx, value) pairs and packs PACK_NUM of them into one memory line.
- Buffers complete lines in an internal FIFO and drains them to the memory write port with a valid/ready handshake.
- Drives the buff_stq_full back-pressure that gates the merge unit's output; supports an end-of-matrix flush of a partial line.

Parameters:
- BITS_ROW_IDX, `BITS_ROW_IDX, row index width
- DATA_PRECISION, `DATA_PRECISION, value width
- PACK_NUM, 4, entries per memory line (power of 2)
- STQ_DEPTH, 8, line FIFO depth (power of 2)
- BITS_STQ_ADDR, 3, log2(STQ_DEPTH)
- FULL_MARGIN, 2, free lines still left when full asserts
- BITS_MEM_ADDR, 32, line address width

Ports:
- clk  in  1  single clock
- rst_b  in  1  synchronous reset, active-high
- unit_en  in  1  block enable; when 0, inputs are ignored and state is held
- flush  in  1  one-cycle pulse: end of stream
- base_addr  in  BITS_MEM_ADDR  line address of the first output line
- in_valid  in  1  merge unit output valid
- in_row_idx  in  BITS_ROW_IDX  merged row index
- in_value  in  DATA_PRECISION  merged value
- buff_stq_full  out  1  back-pressure to the merge unit
- mem_wr_valid  out  1  line available
- mem_wr_ready  in  1  memory accepts the line
- mem_wr_addr  out  BITS_MEM_ADDR  line address
- mem_wr_data  out  PACK_NUM*(BITS_ROW_IDX+DATA_PRECISION)  packed line; slot 0 in the LSBs
- mem_wr_mask  out  PACK_NUM  valid slots in the line
- flush_done  out  1  one-cycle pulse when the flush has completed
- overflow_err  out  1  sticky; set when an entry is dropped

Behaviour:
- Reset values: all outputs 0; slot_ctr=0, line_ctr=0, FIFO empty, FSM in IDLE.
- Accept condition: unit_en && in_valid && state!=DONE. The accepted pair is written into pack register slot slot_ctr and slot_ctr increments.
- Line push: when slot_ctr==PACK_NUM-1 and an entry is accepted, the full pack register (mask all 1s) is pushed into the FIFO on the same edge. Latency from the last accepted entry to mem_wr_valid is 1 cycle.
- FIFO is show-ahead:
  - mem_wr_valid = !fifo_empty.
  - Pop when mem_wr_valid && mem_wr_ready.
  - mem_wr_addr = base_addr + line_ctr; line_ctr increments on each pop and wraps modulo 2^BITS_MEM_ADDR.
  - Simultaneous push and pop keeps the count unchanged; pushing to a full FIFO while popping is legal.
- buff_stq_full is registered: asserts when fifo_count >= STQ_DEPTH-FULL_MARGIN. The margin covers the merge unit's 1-cycle reaction.
- An accept that would push into a FIFO that is full and not popping is dropped: overflow_err is set and stays set until reset.
- FSM:
  - IDLE -> FLUSH_PACK on flush.
  - FLUSH_PACK (1 cycle): if slot_ctr>0, push the partial line with mask = (1<<slot_ctr)-1 and unused slots zero; clear slot_ctr. Next state DRAIN.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE: flush_done=1 for one cycle, then IDLE; line_ctr resets to 0 on that exit.
- If the FIFO is full in FLUSH_PACK, the state holds until space frees.
- in_valid in the same cycle as flush is accepted first; the flush then sees the updated slot_ctr.
- A flush arriving while not in IDLE is ignored.
- unit_en=0 freezes accept and the FSM. The memory drain continues.
- Reset mid-operation discards the partial line and all FIFO contents; no memory write is issued for them.

Decomposition:
- Package stq_pkg:
  - typedef stq_entry_t {row_idx, value}
  - typedef stq_line_t {stq_entry_t [PACK_NUM-1:0] slots; logic [PACK_NUM-1:0] mask}
  - FSM state enum {IDLE, FLUSH_PACK, DRAIN, DONE}
- Sub-module stq_line_fifo: synchronous show-ahead FIFO of stq_line_t with count output. Used once.
- The packer, FSM and address counter live in the top module.

Test Plan:
- 8 consecutive entries (row 0..7, value row*2), mem_wr_ready=1, base_addr=0x100 -> two lines at 0x100 and 0x101, mask 4'b1111, slot0 = (0,0) then (4,8); mem_wr_valid rises 1 cycle after the 4th entry.
- 3 entries then flush -> one line with mask 4'b0111, slot3 = 0; flush_done pulses once the FIFO is empty; next line address restarts at base_addr.
- mem_wr_ready=0 with a continuous input stream -> buff_stq_full asserts when count reaches 6; a source honouring full fills at most 8 lines with no overflow_err; releasing ready drains all 8 lines in order.
- Source ignores buff_stq_full with FIFO at 8 and ready=0 -> the completing entry is dropped, overflow_err=1 and stays set; FIFO contents are unchanged.
- in_valid with flush in the same cycle, slot_ctr=3 -> full line (mask 1111) pushed; FLUSH_PACK pushes nothing.
- Reset asserted mid-stream with 2 lines queued -> next cycle mem_wr_valid=0, buff_stq_full=0, and the next accepted entry lands in slot 0.
